// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: writeback source codes, load sizes, writeback FSM
// states and the stage-3 register layout.
package msrv32_pkg;

  localparam logic [2:0] WB_ALU  = 3'd0;
  localparam logic [2:0] WB_LOAD = 3'd1;
  localparam logic [2:0] WB_IMM  = 3'd2;
  localparam logic [2:0] WB_PC4  = 3'd3;
  localparam logic [2:0] WB_CSR  = 3'd4;

  localparam logic [1:0] LD_B = 2'd0;
  localparam logic [1:0] LD_H = 2'd1;
  localparam logic [1:0] LD_W = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wb_state_e;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        wr_en;
    logic [2:0]  wb_sel;
    logic [1:0]  load_size;
    logic        load_unsigned;
    logic [1:0]  addr_lsb;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] csr;
  } s3_t;

endpackage

// File: rtl/msrv32_load_align.sv
// Selects the addressed byte/half/word from a data-memory read word and
// sign- or zero-extends it to 32 bits.
module msrv32_load_align
  import msrv32_pkg::*;
(
  input  logic [31:0] i_rdata,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  input  logic [1:0]  i_lsb,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_lsb, 3'b000} +: 8];
  // Half loads ignore lsb[0]: misaligned halves never reach this stage.
  assign w_half = i_lsb[1] ? i_rdata[31:16] : i_rdata[15:0];

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves o_data unassigned (no latch).
    o_data = i_rdata;
    case (i_size)
      LD_B:    o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      LD_H:    o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

// File: rtl/msrv32_wb_stage.sv
// msrv32 stage-3 writeback: stage register, load-wait FSM with timeout,
// writeback mux and register-file write port.
module msrv32_wb_stage
  import msrv32_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 15
) (
  input  logic        clock,
  input  logic        reset_in,
  input  logic        valid_in,
  input  logic [4:0]  rd_addr_in,
  input  logic        wr_en_in,
  input  logic [2:0]  wb_sel_in,
  input  logic [31:0] alu_result_in,
  input  logic [31:0] imm_in,
  input  logic [31:0] pc_plus4_in,
  input  logic [31:0] csr_data_in,
  input  logic [1:0]  load_size_in,
  input  logic        load_unsigned_in,
  input  logic [1:0]  addr_lsb_in,
  input  logic [31:0] dmem_rdata_in,
  input  logic        dmem_ack_in,
  output logic [4:0]  rd_addr_out,
  output logic        wr_en_out,
  output logic [31:0] rd_out,
  output logic        stall_out,
  output logic        load_fault_out
);

  localparam int CW = $clog2(LOAD_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_CNT = CW'(LOAD_TIMEOUT);

  s3_t             r_s3;
  wb_state_e       r_state;
  logic [CW-1:0]   r_wait_cnt;

  logic            w_is_load;
  logic            w_timed_out;
  logic            w_accept;
  logic [31:0]     w_load_data;

  assign w_is_load      = r_s3.valid & (r_s3.wb_sel == WB_LOAD);
  assign w_timed_out    = (r_wait_cnt == TIMEOUT_CNT);
  // Ack has priority over timeout: an ack on the timeout cycle is a normal retire.
  assign stall_out      = w_is_load & ~dmem_ack_in & ~w_timed_out;
  assign load_fault_out = w_is_load & ~dmem_ack_in & w_timed_out;
  assign w_accept       = ~stall_out;

  assign rd_addr_out = r_s3.rd;
  assign wr_en_out   = r_s3.valid & r_s3.wr_en & (r_s3.rd != 5'd0)
                     & (~w_is_load | dmem_ack_in);

  msrv32_load_align u_align (
    .i_rdata    (dmem_rdata_in),
    .i_size     (r_s3.load_size),
    .i_unsigned (r_s3.load_unsigned),
    .i_lsb      (r_s3.addr_lsb),
    .o_data     (w_load_data)
  );

  always_comb begin
    rd_out = r_s3.alu;
    case (r_s3.wb_sel)
      WB_LOAD: rd_out = w_load_data;
      WB_IMM:  rd_out = r_s3.imm;
      WB_PC4:  rd_out = r_s3.pc4;
      WB_CSR:  rd_out = r_s3.csr;
      default: rd_out = r_s3.alu;
    endcase
  end

  always_ff @(posedge clock or posedge reset_in) begin
    if (reset_in) begin
      // NOTE: the data operands are cleared too so rd_out reads 0 straight out of reset.
      r_s3       <= '0;
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else if (w_accept) begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      r_s3.valid         <= valid_in;
      r_s3.rd            <= rd_addr_in;
      r_s3.wr_en         <= wr_en_in;
      r_s3.wb_sel        <= wb_sel_in;
      r_s3.load_size     <= load_size_in;
      r_s3.load_unsigned <= load_unsigned_in;
      r_s3.addr_lsb      <= addr_lsb_in;
      r_s3.alu           <= alu_result_in;
      r_s3.imm           <= imm_in;
      r_s3.pc4           <= pc_plus4_in;
      r_s3.csr           <= csr_data_in;
      r_wait_cnt         <= '0;
      r_state            <= (valid_in && wb_sel_in == WB_LOAD) ? ST_WAIT : ST_IDLE;
    end else if (r_state == ST_WAIT && !w_timed_out) begin
      r_wait_cnt <= r_wait_cnt + CW'(1);
    end
  end

endmodule

// File: tb/tb_msrv32_wb_stage.sv
// Self-checking bench for msrv32_wb_stage: vector table, directed multi-cycle
// sequences and a randomized run against a transaction-level reference model.
module tb_msrv32_wb_stage;

  localparam int T = 4;

  typedef struct packed {
    logic        valid;
    logic [4:0]  rd;
    logic        wr_en;
    logic [2:0]  sel;
    logic [1:0]  size;
    logic        uns;
    logic [1:0]  lsb;
    logic [31:0] alu;
    logic [31:0] imm;
    logic [31:0] pc4;
    logic [31:0] csr;
  } instr_t;

  typedef struct packed {
    instr_t      ins;
    logic [31:0] rdata;
    logic        exp_we;
    logic [31:0] exp_data;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset_in;
  logic        valid_in;
  logic [4:0]  rd_addr_in;
  logic        wr_en_in;
  logic [2:0]  wb_sel_in;
  logic [31:0] alu_result_in, imm_in, pc_plus4_in, csr_data_in;
  logic [1:0]  load_size_in;
  logic        load_unsigned_in;
  logic [1:0]  addr_lsb_in;
  logic [31:0] dmem_rdata_in;
  logic        dmem_ack_in;
  logic [4:0]  rd_addr_out;
  logic        wr_en_out;
  logic [31:0] rd_out;
  logic        stall_out;
  logic        load_fault_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clock = ~clock;

  msrv32_wb_stage #(.LOAD_TIMEOUT(T)) dut (
    .clock            (clock),
    .reset_in         (reset_in),
    .valid_in         (valid_in),
    .rd_addr_in       (rd_addr_in),
    .wr_en_in         (wr_en_in),
    .wb_sel_in        (wb_sel_in),
    .alu_result_in    (alu_result_in),
    .imm_in           (imm_in),
    .pc_plus4_in      (pc_plus4_in),
    .csr_data_in      (csr_data_in),
    .load_size_in     (load_size_in),
    .load_unsigned_in (load_unsigned_in),
    .addr_lsb_in      (addr_lsb_in),
    .dmem_rdata_in    (dmem_rdata_in),
    .dmem_ack_in      (dmem_ack_in),
    .rd_addr_out      (rd_addr_out),
    .wr_en_out        (wr_en_out),
    .rd_out           (rd_out),
    .stall_out        (stall_out),
    .load_fault_out   (load_fault_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input instr_t t, input logic [31:0] rdata, input logic ack);
    valid_in         = t.valid;
    rd_addr_in       = t.rd;
    wr_en_in         = t.wr_en;
    wb_sel_in        = t.sel;
    load_size_in     = t.size;
    load_unsigned_in = t.uns;
    addr_lsb_in      = t.lsb;
    alu_result_in    = t.alu;
    imm_in           = t.imm;
    pc_plus4_in      = t.pc4;
    csr_data_in      = t.csr;
    dmem_rdata_in    = rdata;
    dmem_ack_in      = ack;
  endtask

  // One cycle: inputs change just after the edge, outputs are sampled at the falling edge.
  task automatic step(input instr_t t, input logic [31:0] rdata, input logic ack);
    @(posedge clock);
    #1;
    drive(t, rdata, ack);
    @(negedge clock);
  endtask

  function automatic instr_t mk_ins(input logic [2:0] sel, input logic [4:0] rd,
                                    input logic wr_en, input logic [1:0] size,
                                    input logic uns, input logic [1:0] lsb,
                                    input logic [31:0] operand);
    instr_t t;
    t.valid = 1'b1; t.rd = rd; t.wr_en = wr_en; t.sel = sel;
    t.size = size; t.uns = uns; t.lsb = lsb;
    t.alu = 32'hA1A1_A1A1; t.imm = 32'hB2B2_B2B2;
    t.pc4 = 32'hC3C3_C3C3; t.csr = 32'hD4D4_D4D4;
    case (sel)
      3'd1:    ;
      3'd2:    t.imm = operand;
      3'd3:    t.pc4 = operand;
      3'd4:    t.csr = operand;
      default: t.alu = operand;
    endcase
    return t;
  endfunction

  function automatic vec_t mk(input logic [2:0] sel, input logic [4:0] rd, input logic wr_en,
                              input logic [1:0] size, input logic uns, input logic [1:0] lsb,
                              input logic [31:0] operand, input logic [31:0] rdata,
                              input logic exp_we, input logic [31:0] exp_data);
    vec_t v;
    v.ins = mk_ins(sel, rd, wr_en, size, uns, lsb, operand);
    v.rdata = rdata; v.exp_we = exp_we; v.exp_data = exp_data;
    return v;
  endfunction

  // Reference: the value the instruction should write, from the load/mux rules.
  function automatic logic [31:0] ref_data(input instr_t t, input logic [31:0] rdata);
    logic [31:0] v;
    case (t.sel)
      3'd1: begin
        if (t.size == 2'd0) begin
          v = (rdata >> (8 * t.lsb)) & 32'hFF;
          if (!t.uns && v >= 32'd128) v = v | 32'hFFFF_FF00;
        end else if (t.size == 2'd1) begin
          v = (rdata >> (16 * t.lsb[1])) & 32'hFFFF;
          if (!t.uns && v >= 32'd32768) v = v | 32'hFFFF_0000;
        end else begin
          v = rdata;
        end
      end
      3'd2:    v = t.imm;
      3'd3:    v = t.pc4;
      3'd4:    v = t.csr;
      default: v = t.alu;
    endcase
    return v;
  endfunction

  vec_t   vecs [15];
  instr_t bub;
  instr_t ins;
  instr_t m_ins;
  int     m_age;
  logic   ack;
  logic [31:0] rdata;
  logic   e_load, e_stall, e_fault, e_we;

  initial begin
    bub = '0;
    //            sel   rd     we    size  uns   lsb   operand       rdata         exp_we exp_data
    vecs[0]  = mk(3'd0, 5'd5,  1'b1, 2'd0, 1'b0, 2'd0, 32'h1234_5678, 32'h5555_5555, 1'b1, 32'h1234_5678);
    vecs[1]  = mk(3'd2, 5'd7,  1'b1, 2'd0, 1'b0, 2'd0, 32'hDEAD_BEEF, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF);
    vecs[2]  = mk(3'd3, 5'd1,  1'b1, 2'd0, 1'b0, 2'd0, 32'h0000_1004, 32'h5555_5555, 1'b1, 32'h0000_1004);
    vecs[3]  = mk(3'd4, 5'd31, 1'b1, 2'd0, 1'b0, 2'd0, 32'hCAFE_F00D, 32'h5555_5555, 1'b1, 32'hCAFE_F00D);
    vecs[4]  = mk(3'd6, 5'd9,  1'b1, 2'd0, 1'b0, 2'd0, 32'h0000_00AA, 32'h5555_5555, 1'b1, 32'h0000_00AA);
    vecs[5]  = mk(3'd0, 5'd0,  1'b1, 2'd0, 1'b0, 2'd0, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0, 32'hFFFF_FFFF);
    vecs[6]  = mk(3'd0, 5'd3,  1'b0, 2'd0, 1'b0, 2'd0, 32'h0000_0033, 32'h5555_5555, 1'b0, 32'h0000_0033);
    vecs[7]  = mk(3'd1, 5'd8,  1'b1, 2'd1, 1'b1, 2'd2, 32'h0,         32'h8001_0000, 1'b1, 32'h0000_8001);
    vecs[8]  = mk(3'd1, 5'd2,  1'b1, 2'd0, 1'b0, 2'd1, 32'h0,         32'h0000_8000, 1'b1, 32'hFFFF_FF80);
    vecs[9]  = mk(3'd1, 5'd4,  1'b1, 2'd0, 1'b1, 2'd3, 32'h0,         32'hF100_0000, 1'b1, 32'h0000_00F1);
    vecs[10] = mk(3'd1, 5'd6,  1'b1, 2'd1, 1'b0, 2'd0, 32'h0,         32'h1234_9ABC, 1'b1, 32'hFFFF_9ABC);
    vecs[11] = mk(3'd1, 5'd10, 1'b1, 2'd2, 1'b0, 2'd1, 32'h0,         32'h8765_4321, 1'b1, 32'h8765_4321);
    vecs[12] = mk(3'd1, 5'd11, 1'b1, 2'd3, 1'b1, 2'd0, 32'h0,         32'h0F0F_F0F0, 1'b1, 32'h0F0F_F0F0);
    vecs[13] = mk(3'd1, 5'd12, 1'b1, 2'd1, 1'b0, 2'd3, 32'h0,         32'h7FFF_0000, 1'b1, 32'h0000_7FFF);
    vecs[14] = mk(3'd1, 5'd13, 1'b1, 2'd0, 1'b0, 2'd0, 32'h0,         32'h0000_007F, 1'b1, 32'h0000_007F);

    // Reset state
    reset_in = 1'b1;
    drive(bub, 32'h0, 1'b0);
    @(negedge clock);
    check("rst_we",    wr_en_out,      0);
    check("rst_rd",    rd_addr_out,    0);
    check("rst_data",  rd_out,         0);
    check("rst_stall", stall_out,      0);
    check("rst_fault", load_fault_out, 0);
    @(negedge clock);
    reset_in = 1'b0;

    // Table: capture the instruction, then check it (with an immediate ack) behind a bubble
    for (int i = 0; i < 15; i++) begin
      step(vecs[i].ins, 32'h0, 1'b0);
      step(bub, vecs[i].rdata, 1'b1);
      check("tbl_we",    wr_en_out,      vecs[i].exp_we);
      check("tbl_rd",    rd_addr_out,    vecs[i].ins.rd);
      check("tbl_data",  rd_out,         vecs[i].exp_data);
      check("tbl_stall", stall_out,      0);
      check("tbl_fault", load_fault_out, 0);
    end

    // Non-load followed by a bubble: exactly one write
    step(mk_ins(3'd0, 5'd5, 1'b1, 2'd0, 1'b0, 2'd0, 32'h1234_5678), 32'h0, 1'b0);
    step(bub, 32'h0, 1'b0);
    check("alu_we",   wr_en_out, 1);
    check("alu_data", rd_out,    32'h1234_5678);
    step(bub, 32'h0, 1'b0);
    check("bubble_we", wr_en_out, 0);

    // LB lsb=2, ack on the fourth S3 cycle; next instruction waits then captures on the ack edge
    step(mk_ins(3'd1, 5'd12, 1'b1, 2'd0, 1'b0, 2'd2, 32'h0), 32'h0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      step(mk_ins(3'd0, 5'd6, 1'b1, 2'd0, 1'b0, 2'd0, 32'h66), 32'h0080_0000, 1'b0);
      check("lb_stall", stall_out, 1);
      check("lb_wait_we", wr_en_out, 0);
    end
    step(mk_ins(3'd0, 5'd6, 1'b1, 2'd0, 1'b0, 2'd0, 32'h66), 32'h0080_0000, 1'b1);
    check("lb_ack_stall", stall_out, 0);
    check("lb_we",   wr_en_out,   1);
    check("lb_rd",   rd_addr_out, 12);
    check("lb_data", rd_out,      32'hFFFF_FF80);
    step(bub, 32'h0, 1'b0);
    check("after_lb_we",   wr_en_out,   1);
    check("after_lb_rd",   rd_addr_out, 6);
    check("after_lb_data", rd_out,      32'h66);

    // Timeout: T stall cycles, fault pulse in cycle T, no write, next instruction captured
    step(mk_ins(3'd1, 5'd4, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0), 32'h0, 1'b0);
    for (int c = 0; c < T; c++) begin
      step(mk_ins(3'd0, 5'd8, 1'b1, 2'd0, 1'b0, 2'd0, 32'h88), 32'h0, 1'b0);
      check("to_stall", stall_out, 1);
      check("to_fault_early", load_fault_out, 0);
    end
    step(mk_ins(3'd0, 5'd8, 1'b1, 2'd0, 1'b0, 2'd0, 32'h88), 32'h0, 1'b0);
    check("to_stall_rel", stall_out,      0);
    check("to_fault",     load_fault_out, 1);
    check("to_we",        wr_en_out,      0);
    step(bub, 32'h0, 1'b0);
    check("after_to_fault", load_fault_out, 0);
    check("after_to_we",    wr_en_out,      1);
    check("after_to_rd",    rd_addr_out,    8);

    // Ack on the timeout cycle wins
    step(mk_ins(3'd1, 5'd9, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0), 32'h0, 1'b0);
    for (int c = 0; c < T; c++) step(bub, 32'h0, 1'b0);
    step(bub, 32'h1357_9BDF, 1'b1);
    check("ackto_fault", load_fault_out, 0);
    check("ackto_we",    wr_en_out,      1);
    check("ackto_data",  rd_out,         32'h1357_9BDF);

    // Back-to-back loads, each acked in its first cycle
    step(mk_ins(3'd1, 5'd10, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0), 32'h0, 1'b0);
    step(mk_ins(3'd1, 5'd11, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0), 32'hAAAA_0001, 1'b1);
    check("ld1_we",   wr_en_out,   1);
    check("ld1_rd",   rd_addr_out, 10);
    check("ld1_data", rd_out,      32'hAAAA_0001);
    step(bub, 32'hBBBB_0002, 1'b1);
    check("ld2_we",   wr_en_out,   1);
    check("ld2_rd",   rd_addr_out, 11);
    check("ld2_data", rd_out,      32'hBBBB_0002);

    // Reset during WAIT drops the load; a later ack does nothing
    step(mk_ins(3'd1, 5'd13, 1'b1, 2'd2, 1'b0, 2'd0, 32'h0), 32'h0, 1'b0);
    step(bub, 32'h0, 1'b0);
    check("rw_stall", stall_out, 1);
    @(posedge clock);
    #1;
    reset_in = 1'b1;
    #1;
    check("rw_we",    wr_en_out,      0);
    check("rw_rd",    rd_addr_out,    0);
    check("rw_data",  rd_out,         0);
    check("rw_stall0", stall_out,     0);
    check("rw_fault", load_fault_out, 0);
    @(negedge clock);
    reset_in = 1'b0;
    step(bub, 32'hFFFF_FFFF, 1'b1);
    check("rw_ack_we", wr_en_out, 0);
    for (int c = 0; c < T + 2; c++) begin
      step(bub, 32'h0, 1'b0);
      check("rw_no_fault", load_fault_out, 0);
    end

    // Randomized run against the reference model, starting from a fresh reset
    @(posedge clock);
    #1;
    reset_in = 1'b1;
    drive(bub, 32'h0, 1'b0);
    @(negedge clock);
    reset_in = 1'b0;
    m_ins = '0;
    m_age = 0;
    for (int n = 0; n < 600; n++) begin
      ins.valid = ($urandom_range(0, 9) < 8);
      ins.rd    = 5'($urandom_range(0, 31));
      ins.wr_en = ($urandom_range(0, 9) < 9);
      ins.sel   = ($urandom_range(0, 9) < 4) ? 3'd1 : 3'($urandom_range(0, 7));
      ins.size  = 2'($urandom_range(0, 3));
      ins.uns   = 1'($urandom_range(0, 1));
      ins.lsb   = 2'($urandom_range(0, 3));
      ins.alu   = $urandom;
      ins.imm   = $urandom;
      ins.pc4   = $urandom;
      ins.csr   = $urandom;
      rdata     = $urandom;
      ack       = ($urandom_range(0, 9) < 3);
      step(ins, rdata, ack);

      e_load  = m_ins.valid && (m_ins.sel == 3'd1);
      e_stall = e_load && !ack && (m_age < T);
      e_fault = e_load && !ack && (m_age >= T);
      e_we    = m_ins.valid && m_ins.wr_en && (m_ins.rd != 0) && (!e_load || ack);
      check("rnd_stall", stall_out,      e_stall);
      check("rnd_fault", load_fault_out, e_fault);
      check("rnd_we",    wr_en_out,      e_we);
      if (m_ins.valid) begin
        check("rnd_rd",   rd_addr_out, m_ins.rd);
        check("rnd_data", rd_out,      ref_data(m_ins, rdata));
      end

      if (!e_stall) begin
        m_ins = ins;
        m_age = 0;
      end else begin
        m_age++;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/msrv32_wb_stage.md
# msrv32_wb_stage

Stage-3 writeback block of the msrv32 core. Registers one instruction per cycle from stage 2, waits for the data-memory response on loads, aligns and extends load data, and selects the writeback value. It drives the write port of the integer register file (`rd_addr_out`, `wr_en_out`, `rd_out`) and back-pressures stage 2 through `stall_out` while a load is outstanding.

## Interface
- `LOAD_TIMEOUT`, default 15: number of no-ack cycles tolerated before a load is abandoned; legal range 1–255.
- `clock`  in  1  core clock.
- `reset_in`  in  1  reset, asynchronous, active-high.
- `valid_in`  in  1  stage 2 presents an instruction; low means a bubble.
- `rd_addr_in`  in  5  destination register.
- `wr_en_in`  in  1  instruction writes rd.
- `wb_sel_in`  in  3  writeback source: 0 ALU, 1 load, 2 imm, 3 PC+4, 4 CSR, 5–7 treated as ALU.
- `alu_result_in`, `imm_in`, `pc_plus4_in`, `csr_data_in`  in  32 each  candidate writeback values.
- `load_size_in`  in  2  0 byte, 1 half, 2 word, 3 treated as word.
- `load_unsigned_in`  in  1  zero-extend instead of sign-extend.
- `addr_lsb_in`  in  2  low two bits of the load address.
- `dmem_rdata_in`  in  32  data-memory read word.
- `dmem_ack_in`  in  1  read data is valid this cycle.
- `rd_addr_out`  out  5  register-file write address.
- `wr_en_out`  out  1  register-file write enable.
- `rd_out`  out  32  register-file write data.
- `stall_out`  out  1  stage 2 must hold its outputs.
- `load_fault_out`  out  1  one-cycle pulse when a load times out.

## Operation
- **Stage register.** S3 holds valid, rd, wr_en, wb_sel, load_size, unsigned, addr_lsb and the four data operands.
  - It captures on `accept = ~stall_out`. With `valid_in` low it captures a bubble (`s3_valid = 0`).
- **State machine.**
  - IDLE → WAIT when accept captures a valid load (`wb_sel == 1`).
  - WAIT → IDLE on `dmem_ack_in`, on timeout, or when accept captures a non-load.
  - WAIT → WAIT (reload) when accept captures another load.
  - `wait_cnt` has width `$clog2(LOAD_TIMEOUT+1)`. It clears on every capture and increments each WAIT cycle without ack, saturating at `LOAD_TIMEOUT`.
- **Load alignment** (`wb_sel == 1`).
  - Byte: `dmem_rdata_in[8*lsb +: 8]`.
  - Half: `dmem_rdata_in[16*lsb[1] +: 16]`; `lsb[0]` is ignored because misalignment is trapped upstream.
  - Word: the full word.
  - Byte and half are sign-extended unless `load_unsigned_in`.
- **rd_out.** Combinational mux of the S3 operands and the aligned load data, selected by `wb_sel`.
- **rd_addr_out.** Equals S3 rd.
- **wr_en_out.** `s3_valid & s3_wr_en & (rd != 0) & (~is_load | dmem_ack_in)`.
- **stall_out.** `s3_valid & is_load & ~dmem_ack_in & (wait_cnt != LOAD_TIMEOUT)`.
- **load_fault_out.** `s3_valid & is_load & ~dmem_ack_in & (wait_cnt == LOAD_TIMEOUT)`. On a fault, no write occurs and the stall is released.
- A load retires exactly once, on its ack cycle or its fault cycle. An ack while no load is in S3 is ignored.

## Timing
- **Reset.** All S3 fields clear and the state is IDLE. `wr_en_out=0`, `rd_addr_out=0`, `rd_out=0`, `stall_out=0`, `load_fault_out=0`.
- **Reset during WAIT.** The load is dropped with no write and no fault pulse.
- **Non-load latency.** The instruction is captured at edge N and its write is visible during cycle N→N+1; the register file commits it at edge N+1.
- **Loads.**
  - With ack in the first S3 cycle, latency is the same as a non-load.
  - Otherwise the write occurs in the ack cycle, and `stall_out` drops combinationally in that cycle, so the next instruction is captured at the same edge the register file commits the load.
- **Timeout.** With no ack, `stall_out` is high for cycles 0 … LOAD_TIMEOUT−1 of S3 residency. `load_fault_out` pulses in cycle LOAD_TIMEOUT.
- **Ack on the timeout cycle.** Ack wins: normal write, no fault.
- **Throughput.** Back-to-back non-loads retire one per cycle.

## Structure
- **Shared package `msrv32_pkg`:** wb_sel codes (`WB_ALU`, `WB_LOAD`, `WB_IMM`, `WB_PC4`, `WB_CSR`), load size codes (`LD_B`, `LD_H`, `LD_W`), and the WAIT/IDLE state enum.
- **Sub-module `msrv32_load_align`:** purely combinational; inputs rdata, size, unsigned and lsb; output the 32-bit extended value.
- **Top level:** the stage register, FSM, counter and output logic.

## Test plan
- **Non-load bubbles.** ALU op with rd=5 and `alu_result_in=0x1234_5678`, then a bubble → `wr_en_out=1`, `rd_out=0x12345678` for one cycle, then `wr_en_out=0`.
- **Sign-extended byte.** LB, lsb=2, `dmem_rdata_in=0x00_80_00_00`, ack after 3 cycles → `stall_out` high 3 cycles; write of `0xFFFF_FF80` in the ack cycle.
- **Unsigned half.** LHU, lsb=2, `rdata=0x8001_0000`, immediate ack → no stall; `rd_out=0x0000_8001`.
- **Timeout.** Load with `LOAD_TIMEOUT=4` and no ack → stall for 4 cycles, `load_fault_out` pulse in the 5th cycle, no write; next instruction captured.
- **x0 and load-to-load.**
  - Write to rd=0 → `wr_en_out=0`.
  - Two back-to-back loads with acks → two writes, each holding its own rd and data.
- **Reset during WAIT.** Assert `reset_in` mid-WAIT → all outputs 0 immediately; a later ack is ignored.
